// File: rtl/vmac_pkg.sv
// Shared definitions for the vmac_pipe SIMD multiply/accumulate slice:
// op encoding and default geometry.
package vmac_pkg;

    localparam int LANES_DEF = 16;
    localparam int EW_DEF    = 16;
    localparam int FRAC_DEF  = 15;

    typedef enum logic [1:0] {
        MUL_LO  = 2'b00,
        MUL_HI  = 2'b01,
        MAC     = 2'b10,
        CLR_MAC = 2'b11
    } op_e;

endpackage

// File: rtl/vmac_lane.sv
// One SIMD lane: S1 product register, accumulator, shift and narrowing.
// Define VMAC_SAT_EN to clamp narrowed results; otherwise they wrap.
module vmac_lane
    import vmac_pkg::*;
#(
    parameter int EW   = EW_DEF,
    parameter int FRAC = FRAC_DEF,
    parameter int ACCW = 2*EW+8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld,
    input  logic          cap,
    input  op_e           op_s1,
    input  logic [EW-1:0] a,
    input  logic [EW-1:0] b,
    output logic [EW-1:0] result,
    output logic          sat
);

    logic signed [2*EW-1:0] prod;
    logic signed [ACCW-1:0] acc;
    logic signed [ACCW-1:0] prod_ext;
    logic signed [ACCW-1:0] acc_nxt;
    logic signed [ACCW-1:0] src;
    logic signed [ACCW-1:0] shifted;
    logic        [EW-1:0]   narrowed;
    logic                   clamped;

    always_ff @(posedge clk) begin
        if (rst) begin
            prod <= '0;
        end else if (ld) begin
            prod <= $signed(a) * $signed(b);
        end
    end

    always_comb begin
        prod_ext = {{(ACCW-2*EW){prod[2*EW-1]}}, prod};
        acc_nxt  = acc;
        case (op_s1)
            CLR_MAC: acc_nxt = prod_ext;
            MAC:     acc_nxt = acc + prod_ext;
            default: acc_nxt = acc;
        endcase
        src     = (op_s1 == MUL_HI) ? prod_ext : acc_nxt;
        shifted = src >>> FRAC;
    end

`ifdef VMAC_SAT_EN
    logic [ACCW-EW:0] hi;

    // In range exactly when every bit from EW-1 upward matches the sign.
    always_comb begin
        hi = shifted[ACCW-1:EW-1];
        if ((&hi) || !(|hi)) begin
            narrowed = shifted[EW-1:0];
            clamped  = 1'b0;
        end else begin
            narrowed = shifted[ACCW-1] ? {1'b1, {(EW-1){1'b0}}} : {1'b0, {(EW-1){1'b1}}};
            clamped  = 1'b1;
        end
    end
`else
    logic unused_hi;

    always_comb begin
        narrowed  = shifted[EW-1:0];
        clamped   = 1'b0;
        unused_hi = ^shifted[ACCW-1:EW];
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            result <= '0;
            sat    <= 1'b0;
        end else if (cap) begin
            acc <= acc_nxt;
            if (op_s1 == MUL_LO) begin
                result <= prod[EW-1:0];
                sat    <= 1'b0;
            end else begin
                result <= narrowed;
                sat    <= clamped;
            end
        end
    end

endmodule

// File: rtl/vmac_pipe.sv
// Two-stage SIMD fixed-point multiply / multiply-accumulate pipeline with
// valid/ready handshake. Define VMAC_SAT_EN to enable result saturation.
module vmac_pipe
    import vmac_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int EW    = EW_DEF,
    parameter int FRAC  = FRAC_DEF,
    parameter int ACCW  = 2*EW+8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          op,
    input  logic [LANES*EW-1:0] a,
    input  logic [LANES*EW-1:0] b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [LANES*EW-1:0] result,
    output logic [LANES-1:0]    sat
);

    logic advance;
    logic accept;
    logic capture;
    logic s1_valid;
    op_e  s1_op;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;
    assign accept   = in_valid && advance;
    assign capture  = advance && s1_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_op     <= MUL_LO;
            out_valid <= 1'b0;
        end else if (advance) begin
            s1_valid  <= in_valid;
            out_valid <= s1_valid;
            if (in_valid) begin
                s1_op <= op_e'(op);
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        vmac_lane #(
            .EW   (EW),
            .FRAC (FRAC),
            .ACCW (ACCW)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .ld     (accept),
            .cap    (capture),
            .op_s1  (s1_op),
            .a      (a[i*EW +: EW]),
            .b      (b[i*EW +: EW]),
            .result (result[i*EW +: EW]),
            .sat    (sat[i])
        );
    end

endmodule

// File: doc/vmac_pipe.md
VMAC_PIPE -- requirements
Module: vmac_pipe

Interface
REQ-001 Parameter LANES, default 16: number of independent SIMD lanes.
REQ-002 Parameter EW, default 16: element width in bits, for operands and results.
REQ-003 Parameter FRAC, default 15: fixed-point fraction bits, the right-shift applied in Q modes.
REQ-004 Parameter ACCW, default 2*EW+8: per-lane accumulator width.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 in_valid  in  1  input beat offered.
REQ-008 in_ready  out  1  block can accept a beat this cycle.
REQ-009 op  in  2  operation: 00 MUL_LO, 01 MUL_HI, 10 MAC, 11 CLR_MAC.
REQ-010 a, b  in  LANES*EW  operand vectors; lane i occupies bits [i*EW +: EW].
REQ-011 out_valid  out  1  result beat present.
REQ-012 out_ready  in  1  consumer accepts the result beat.
REQ-013 result  out  LANES*EW  result vector, same lane packing as a and b.
REQ-014 sat  out  LANES  per-lane flag: this beat was clamped.

Function
REQ-015 A beat SHALL be accepted when in_valid && in_ready; a result SHALL be consumed when out_valid && out_ready.
REQ-016 Pipeline: two stages. S1 registers the signed EW x EW products. S2 performs shift, accumulate and clamp, and registers result.
REQ-017 advance = !out_valid || out_ready; both stages SHALL move only when advance=1.
REQ-018 in_ready SHALL equal advance; in_ready is not gated by in_valid.
REQ-019 Latency SHALL be exactly 2 cycles from acceptance to out_valid when out_ready is held high; sustained throughput SHALL be 1 beat/cycle.
REQ-020 While advance=0: result, sat, out_valid and S1 contents SHALL be held stable, and the accumulators SHALL NOT change.
REQ-021 MUL_LO: lane result = low EW bits of the product; this is bit-identical to the unsigned/signed low product, and sat=0.
REQ-022 MUL_HI: lane result = signed product >>> FRAC (arithmetic shift), then narrowed to EW bits per REQ-032/033.
REQ-023 CLR_MAC: acc = sign-extended product; lane result = acc >>> FRAC, narrowed.
REQ-024 MAC: acc = acc + sign-extended product; lane result = new acc >>> FRAC, narrowed.
REQ-025 Each accumulator SHALL update exactly once per beat, at S2 capture; accumulator overflow wraps two's-complement at ACCW bits.
REQ-026 op SHALL be carried through S1 alongside its beat, so a mode change between consecutive beats takes effect per beat.
REQ-027 MUL_LO and MUL_HI SHALL leave the accumulators untouched.
REQ-028 Lanes are fully independent; there is no carry or flag interaction between lanes.

Reset
REQ-029 With rst=1 at a clock edge, the following SHALL be 0 the next cycle: out_valid, result, sat, the S1 valid bit and all accumulators.
REQ-030 Reset mid-stream SHALL discard in-flight beats with no partial output; in_ready SHALL be 1 in the cycle after reset deasserts.
REQ-031 rst SHALL take priority over any simultaneous accept or consume.

Configuration
REQ-032 With VMAC_SAT_EN defined: the narrowing in MUL_HI, MAC and CLR_MAC SHALL clamp to [-2^(EW-1), 2^(EW-1)-1], and sat[i]=1 when lane i was clamped.
REQ-033 With VMAC_SAT_EN undefined: narrowing SHALL take the low EW bits (wrap), and sat SHALL be tied to 0.

Structure
REQ-034 Package vmac_pkg SHALL hold the op encoding (MUL_LO, MUL_HI, MAC, CLR_MAC) and the default values of EW, FRAC and LANES.
REQ-035 Sub-module vmac_lane SHALL hold one lane's product register, accumulator and narrowing logic, instantiated LANES times by generate; handshake control stays in vmac_pipe.

Verification (EW=16, FRAC=15, LANES=16)
REQ-036 MUL_LO, lane0 3*5 and lane15 0xFFFF*0x0002 -> 0x000F and 0xFFFE, out_valid exactly 2 cycles after accept.
REQ-037 MUL_HI, 0x4000*0x4000 -> 0x2000; 0x8000*0x8000 -> 0x7FFF with sat=1 when VMAC_SAT_EN, else 0x8000 with sat=0.
REQ-038 CLR_MAC then MAC, MAC on lane0 with 0x4000*0x4000 -> results 0x2000, 0x4000, 0x6000; a MUL_LO beat in between leaves acc unchanged.
REQ-039 3 beats offered with out_ready=0 for 5 cycles -> in_ready drops once full, result held, all 3 beats delivered in order with none lost or duplicated, acc advanced exactly 3 times.
REQ-040 rst with 2 beats in flight -> out_valid=0 the next cycle; a subsequent MAC 0x4000*0x4000 returns 0x2000.
REQ-041 Random back-to-back beats with random out_ready, compared against a per-lane reference model -> zero mismatches over 10,000 beats.
